branch_predict_ctrl: RTL
========================

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge); rst_n input 1 (asynchronous, active-low).
REQ-002 Parameter: ENTRIES, default 16 (power of two), number of prediction-table entries.
REQ-003 Fetch-side ports SHALL be:
- fetch_pc input 32: PC being fetched.
- pred_taken output 1: predict taken.
- pred_target output 32: predicted target.
REQ-004 Resolve-side ports SHALL be:
- ex_valid input 1: EX holds a valid instruction.
- ex_is_branch input 1: conditional branch.
- ex_is_jump input 1: JAL/JALR.
- ex_pc input 32: PC of the EX instruction.
- ex_taken input 1: actual outcome, PCSrc != 2'b00.
- ex_target input 32: actual target.
- ex_pred_taken input 1: prediction carried down the pipe.
- ex_pred_target input 32: predicted target carried down the pipe.
- stall input 1: pipeline stall.
REQ-005 Control and status ports SHALL be:
- redirect output 1: PC mux override.
- redirect_pc output 32: corrected PC.
- flush output 1: clear IF/ID and ID/EX.
- branch_count output 16: resolved control-transfer count.
- mispredict_count output 16: mispredict count.

Function
REQ-006 The table SHALL hold ENTRIES entries. Each entry: valid, tag = PC[31:2+log2(ENTRIES)], target[31:0], 2-bit counter ctr. Index = PC[1+log2(ENTRIES):2].
REQ-007 Lookup SHALL be combinational on fetch_pc.
- pred_taken = valid & tag match & ctr[1].
- pred_target = entry target when pred_taken, else fetch_pc+4 (mod 2^32).
REQ-008 A resolve event SHALL be ex_valid & (ex_is_branch | ex_is_jump) & ~stall & state==IDLE.
REQ-009 Mispredict SHALL be a resolve event with (ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target).
REQ-010 Table update on a resolve event, at the clock edge:
- Tag miss or invalid entry: allocate with valid=1, tag, target=ex_target, ctr = jump ? 2'b11 : (ex_taken ? 2'b10 : 2'b01).
- Tag hit: ctr saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00); jump forces 11.
- target is written only when ex_taken.
REQ-011 A same-cycle lookup and update to the same index SHALL return the pre-update entry (no bypass).
REQ-012 FSM states SHALL be IDLE and REDIRECT.
- IDLE -> REDIRECT on mispredict.
- REDIRECT -> IDLE unconditionally after one cycle.
REQ-013 In REDIRECT:
- redirect=1 and flush=1 for exactly one cycle.
- redirect_pc = registered (ex_taken ? ex_target : ex_pc+4) captured at the mispredict edge.
REQ-014 In IDLE, redirect=0 and flush=0; redirect_pc holds its last value.
REQ-015 Redirect latency SHALL be one cycle: mispredict resolved in cycle N gives redirect in cycle N+1.
REQ-016 In REDIRECT, EX inputs SHALL be ignored (wrong-path): no table update, no count, no new mispredict. stall SHALL NOT extend REDIRECT.
REQ-017 When stall=1 in IDLE, there SHALL be no resolve event, no update and no count.
REQ-018 branch_count SHALL increment on every resolve event. mispredict_count SHALL increment on every mispredict. Both saturate at 16'hFFFF.

Reset
REQ-019 rst_n low SHALL asynchronously force:
- all valid=0 and all ctr=2'b01;
- state=IDLE;
- redirect=0, flush=0, redirect_pc=0;
- both counters 0.
This produces pred_taken=0 and pred_target=fetch_pc+4.
REQ-020 Reset asserted during REDIRECT SHALL drop the pending redirect. The first cycle after release SHALL be IDLE with redirect=0.

Verification
REQ-021 Cold predict: after reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-022 Taken branch:
- Stimulus: BEQ at ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0.
- Response: next cycle redirect=1, flush=1, redirect_pc=0x80; following cycle redirect=0.
- Table: entry ctr=10; fetch_pc=0x100 then gives pred_taken=1, pred_target=0x80.
- Counters: mispredict_count=1, branch_count=1.
REQ-023 Counter saturation:
- Four taken resolves at 0x100 -> ctr=11.
- Then two not-taken -> ctr=01 and pred_taken=0.
- A third not-taken -> ctr=00; a fourth stays 00.
REQ-024 Wrong-path suppression:
- Stimulus: mispredict in cycle N, second branch with ex_valid=1 in cycle N+1.
- Response: no update and no count from the second branch; branch_count increments by 1 only.
REQ-025 Stall and reset:
- stall=1 with a mispredicting branch -> no redirect and counters unchanged.
- rst_n pulsed low during REDIRECT -> redirect=0 immediately and all table entries invalid.
REQ-026 Tag alias: with ENTRIES=16, a taken branch at 0x100 then a resolve at 0x140 (same index, different tag) -> the entry is reallocated and fetch_pc=0x100 gives pred_taken=0.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Branch predictor with a direct-mapped target table and 2-bit counters, plus a
// one-cycle redirect/flush controller driven by mispredicts resolved in EX.
module branch_predict_ctrl #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  logic            valid_r  [ENTRIES];
  logic [TAGW-1:0] tag_r    [ENTRIES];
  logic [31:0]     target_r [ENTRIES];
  logic [1:0]      ctr_r    [ENTRIES];

  state_t          state_r;
  state_t          state_nxt_s;
  logic            redirect_r;
  logic            flush_r;
  logic [31:0]     redirect_pc_r;
  logic [15:0]     branch_count_r;
  logic [15:0]     mispredict_count_r;

  logic [IDXW-1:0] fidx_s;
  logic [TAGW-1:0] ftag_s;
  logic            fhit_s;
  logic [IDXW-1:0] eidx_s;
  logic [TAGW-1:0] etag_s;
  logic            ehit_s;
  logic [1:0]      ctr_upd_s;
  logic            resolve_s;
  logic            mispredict_s;

  assign fidx_s = fetch_pc[IDXW+1:2];
  assign ftag_s = fetch_pc[31:IDXW+2];
  assign eidx_s = ex_pc[IDXW+1:2];
  assign etag_s = ex_pc[31:IDXW+2];

  // Fetch-side lookup reads the registered table, so a same-index update is not bypassed
  always_comb begin
    fhit_s      = valid_r[fidx_s] && (tag_r[fidx_s] == ftag_s);
    pred_taken  = fhit_s && ctr_r[fidx_s][1];
    pred_target = pred_taken ? target_r[fidx_s] : (fetch_pc + 32'd4);
  end

  // Wrong-path EX contents during REDIRECT never resolve
  always_comb begin
    resolve_s    = ex_valid && (ex_is_branch || ex_is_jump) && !stall && (state_r == IDLE);
    mispredict_s = resolve_s &&
                   ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  end

  // Counter update: allocate on miss, saturating step on hit, jumps pinned strongly taken
  always_comb begin
    ehit_s    = valid_r[eidx_s] && (tag_r[eidx_s] == etag_s);
    ctr_upd_s = ctr_r[eidx_s];
    if (ex_is_jump) begin
      ctr_upd_s = 2'b11;
    end else if (!ehit_s) begin
      ctr_upd_s = ex_taken ? 2'b10 : 2'b01;
    end else if (ex_taken) begin
      ctr_upd_s = (ctr_r[eidx_s] == 2'b11) ? 2'b11 : (ctr_r[eidx_s] + 2'd1);
    end else begin
      ctr_upd_s = (ctr_r[eidx_s] == 2'b00) ? 2'b00 : (ctr_r[eidx_s] - 2'd1);
    end
  end

  // Prediction table storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (resolve_s) begin
      valid_r[eidx_s] <= 1'b1;
      tag_r[eidx_s]   <= etag_s;
      ctr_r[eidx_s]   <= ctr_upd_s;
      if (!ehit_s || ex_taken) begin
        target_r[eidx_s] <= ex_target;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: REDIRECT lasts exactly one cycle regardless of stall
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     state_nxt_s = mispredict_s ? REDIRECT : IDLE;
      REDIRECT: state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Registered redirect/flush strobes and the corrected PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_r    <= 1'b0;
      flush_r       <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      redirect_r <= (state_nxt_s == REDIRECT);
      flush_r    <= (state_nxt_s == REDIRECT);
      if (mispredict_s) begin
        redirect_pc_r <= ex_taken ? ex_target : (ex_pc + 32'd4);
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_r     <= 16'd0;
      mispredict_count_r <= 16'd0;
    end else begin
      if (resolve_s && (branch_count_r != 16'hFFFF)) begin
        branch_count_r <= branch_count_r + 16'd1;
      end
      if (mispredict_s && (mispredict_count_r != 16'hFFFF)) begin
        mispredict_count_r <= mispredict_count_r + 16'd1;
      end
    end
  end

  assign redirect         = redirect_r;
  assign flush            = flush_r;
  assign redirect_pc      = redirect_pc_r;
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule
